relu2_seq_ctrl: RTL and testbench

- Sequencer for the second ReLU layer of the CNN datapath.
- On `start`, streams every word of the conv2 output buffer through one registered ReLU stage and writes the results into the pool2 input buffer.
- Ends with a one-cycle `done` pulse.
- Replaces free-running enable-driven ReLU activity with a counted, address-driven pass.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/relu2_seq_ctrl_if.sv | 48 ++++
 rtl/relu_stage.sv | 51 +++++
 rtl/relu2_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_relu2_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
//============================================================================
// Module : cnn_pkg
// Brief  : Shared CNN datapath constants and the relu2 sequencer state type.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package cnn_pkg;

  localparam int CNN_DATA_W   = 30;
  localparam int RELU2_DEPTH  = 800;
  localparam int RELU2_ADDR_W = 10;

  typedef enum logic [1:0] {
    RELU2_IDLE  = 2'd0,
    RELU2_READ  = 2'd1,
    RELU2_DRAIN = 2'd2,
    RELU2_DONE  = 2'd3
  } relu2_state_t;

endpackage

`default_nettype wire

// File: rtl/relu2_seq_ctrl_if.sv
//============================================================================
// Module : relu2_seq_ctrl_if
// Brief  : Control and buffer-port bundle of the relu2 sequencer.
//          neg_cnt exists only when RELU2_NEG_CNT_EN is defined.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface relu2_seq_ctrl_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int ADDR_W = RELU2_ADDR_W
) ();

  logic                     start;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
`ifdef RELU2_NEG_CNT_EN
  logic [ADDR_W:0]          neg_cnt;
`endif

  modport master (
    input  start, abort, rd_data,
`ifdef RELU2_NEG_CNT_EN
    output neg_cnt,
`endif
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, rd_data,
`ifdef RELU2_NEG_CNT_EN
    input  neg_cnt,
`endif
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

`default_nettype wire

// File: rtl/relu_stage.sv
//============================================================================
// Module : relu_stage
// Brief  : Registered signed max(x,0) with valid and address pipeline.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module relu_stage #(
  parameter int DATA_W = 30,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  output logic [ADDR_W-1:0]        o_addr,
  output logic signed [DATA_W-1:0] o_data
);

  logic                     r_valid;
  logic [ADDR_W-1:0]        r_addr;
  logic signed [DATA_W-1:0] r_data;
  logic                     w_pos;
  logic signed [DATA_W-1:0] w_relu;

  // Strictly positive: sign clear and not zero (covers the most-negative word).
  assign w_pos  = ~i_data[DATA_W-1] & (|i_data);
  assign w_relu = w_pos ? i_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      r_addr  <= i_addr;
      r_data  <= w_relu;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/relu2_seq_ctrl.sv
//============================================================================
// Module : relu2_seq_ctrl
// Brief  : Counted address-driven ReLU pass from conv2 buffer to pool2 buffer.
//          Define RELU2_NEG_CNT_EN to add the negative-element counter.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module relu2_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int DEPTH  = RELU2_DEPTH,
  parameter int ADDR_W = RELU2_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  relu2_seq_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  relu2_state_t             r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_rd_en;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic                     r_drain_cnt;
  logic                     r_rd_vld_d;
  logic [ADDR_W-1:0]        r_rd_addr_d;
  logic                     w_accept;
  logic                     w_wr_en;
  logic [ADDR_W-1:0]        w_wr_addr;
  logic signed [DATA_W-1:0] w_wr_data;

  assign w_accept = (r_state == RELU2_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.abort) begin
      r_state     <= RELU2_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      case (r_state)
        RELU2_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state   <= RELU2_READ;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        RELU2_READ: begin
          // Address stops at the last word; it never wraps.
          if (r_rd_addr == c_last_addr) begin
            r_state     <= RELU2_DRAIN;
            r_rd_en     <= 1'b0;
            r_drain_cnt <= 1'b0;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        RELU2_DRAIN: begin
          if (r_drain_cnt) begin
            r_state     <= RELU2_DONE;
            r_done      <= 1'b1;
            r_drain_cnt <= 1'b0;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        RELU2_DONE: begin
          r_state <= RELU2_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= RELU2_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Read strobe/address delayed one cycle to line up with the returning data.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.abort) begin
      r_rd_vld_d  <= 1'b0;
      r_rd_addr_d <= '0;
    end else begin
      r_rd_vld_d  <= r_rd_en;
      r_rd_addr_d <= r_rd_addr;
    end
  end

  relu_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_relu_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (bus.abort),
    .i_valid (r_rd_vld_d),
    .i_addr  (r_rd_addr_d),
    .i_data  (bus.rd_data),
    .o_valid (w_wr_en),
    .o_addr  (w_wr_addr),
    .o_data  (w_wr_data)
  );

`ifdef RELU2_NEG_CNT_EN
  logic [ADDR_W:0] r_neg_cnt;

  // Counted alongside the ReLU register so the value is final by the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_cnt <= '0;
    end else if (w_accept) begin
      r_neg_cnt <= '0;
    end else if (!bus.abort && r_rd_vld_d && bus.rd_data[DATA_W-1]) begin
      r_neg_cnt <= r_neg_cnt + (ADDR_W+1)'(1);
    end
  end

  assign bus.neg_cnt = r_neg_cnt;
`endif

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = w_wr_en;
  assign bus.wr_addr = w_wr_addr;
  assign bus.wr_data = w_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_relu2_seq_ctrl.sv
//============================================================================
// Module : tb_relu2_seq_ctrl
// Brief  : Scoreboard bench for relu2_seq_ctrl (DEPTH=8, ADDR_W=3).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_relu2_seq_ctrl;
  import cnn_pkg::*;

  localparam int DW    = CNN_DATA_W;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu2_seq_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  relu2_seq_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [DW-1:0] src [DEPTH];

  // Source buffer: one-cycle read latency, data only in the return cycle.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
    else           bus.rd_data <= '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; logic signed [DW-1:0] data; } wr_t;
  typedef struct { int cyc; int neg; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [DW-1:0] relu_ref(input logic signed [DW-1:0] x);
    longint v;
    v = longint'(x);
    return (v > 0) ? x : '0;
  endfunction

  function automatic logic signed [DW-1:0] rand_word(input bit pos_only);
    logic signed [DW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = {1'b1, {(DW-1){1'b0}}};
      2:       v = {1'b0, {(DW-1){1'b1}}};
      default: v = DW'($urandom);
    endcase
    if (pos_only && longint'(v) <= 0) v = DW'($urandom_range(1, 1000));
    return v;
  endfunction

  // Reference model state: m_e is the first cycle of the current pass.
  bit seen_rst  = 1'b0;
  bit chk_zero  = 1'b0;
  bit chk_addr0 = 1'b0;
  bit m_active  = 1'b0;
  int m_e       = 0;

  always @(negedge clk) begin
    int c;
    bit eb, er;
    int nneg;
    wr_t w;
    dn_t d;
    c = cyc;
    if (seen_rst) begin
      if (chk_zero) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", longint'(bus.wr_data), 0);
`ifdef RELU2_NEG_CNT_EN
        chk("rst_neg_cnt", bus.neg_cnt, 0);
`endif
      end
      if (chk_addr0) begin
        chk("abort_rd_addr", bus.rd_addr, 0);
        chk("abort_wr_addr", bus.wr_addr, 0);
      end
      eb = m_active && c >= m_e && c <= m_e + DEPTH + 2;
      er = m_active && c >= m_e && c <= m_e + DEPTH - 1;
      chk("busy", bus.busy, eb);
      chk("rd_en", bus.rd_en, er);
      if (er) chk("rd_addr", bus.rd_addr, c - m_e);

      if (bus.wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_cycle", c, w.cyc);
          chk("wr_addr", bus.wr_addr, w.addr);
          chk("wr_data", longint'(bus.wr_data), longint'(w.data));
        end
      end else if (wq.size() > 0 && wq[0].cyc == c) begin
        chk("wr_missing", 0, 1);
        void'(wq.pop_front());
      end

      if (bus.done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", c, d.cyc);
`ifdef RELU2_NEG_CNT_EN
          chk("neg_cnt", bus.neg_cnt, d.neg);
`endif
        end
      end else if (dq.size() > 0 && dq[0].cyc == c) begin
        chk("done_missing", 0, 1);
        void'(dq.pop_front());
      end
    end

    // Predict the effect of the inputs sampled at the coming edge.
    chk_zero  = 1'b0;
    chk_addr0 = 1'b0;
    if (!rst_n) begin
      seen_rst = 1'b1;
      chk_zero = 1'b1;
      m_active = 1'b0;
      wq.delete();
      dq.delete();
    end else if (bus.abort) begin
      if (m_active && c <= m_e + DEPTH + 2) chk_addr0 = 1'b1;
      m_active = 1'b0;
      wq.delete();
      dq.delete();
    end else if (bus.start && !(m_active && c <= m_e + DEPTH + 2)) begin
      m_active = 1'b1;
      m_e      = c + 1;
      nneg     = 0;
      for (int i = 0; i < DEPTH; i++) begin
        wq.push_back('{cyc: m_e + 2 + i, addr: i, data: relu_ref(src[i])});
        if (longint'(src[i]) < 0) nneg++;
      end
      dq.push_back('{cyc: m_e + DEPTH + 2, neg: nneg});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input bit pos_only);
    for (int i = 0; i < DEPTH; i++) src[i] = rand_word(pos_only);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) src[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed vector with zero, negatives and both extremes.
    src[0] = 30'sd5;
    src[1] = -30'sd3;
    src[2] = 30'sd0;
    src[3] = 30'sd1;
    src[4] = -30'sd1;
    src[5] = {1'b1, {(DW-1){1'b0}}};
    src[6] = {1'b0, {(DW-1){1'b1}}};
    src[7] = 30'sd7;
    pulse_start();
    repeat (DEPTH + 5) tick();

    // All-positive pass: no negatives to count.
    fill_random(1'b1);
    pulse_start();
    repeat (DEPTH + 5) tick();

    // start held high across three back-to-back passes.
    fill_random(1'b0);
    bus.start = 1'b1;
    repeat (2 * (DEPTH + 4) + 2) tick();
    bus.start = 1'b0;
    repeat (DEPTH + 5) tick();

    // abort during cycle 5, then a clean pass.
    fill_random(1'b0);
    pulse_start();
    repeat (4) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (4) tick();
    fill_random(1'b0);
    pulse_start();
    repeat (DEPTH + 5) tick();

    // start and abort together in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (10) tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();

    // Reset during the first DRAIN cycle.
    fill_random(1'b0);
    pulse_start();
    repeat (DEPTH) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Random passes, some aborted, some with stray start pulses while busy.
    for (int p = 0; p < 8; p++) begin
      fill_random(1'b0);
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, DEPTH + 2)) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (DEPTH + 5) tick();
      end else begin
        for (int i = 0; i < DEPTH + 6; i++) begin
          bus.start = (i < DEPTH) ? ($urandom_range(0, 3) == 0) : 1'b0;
          tick();
        end
      end
    end

    repeat (5) tick();
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
